// File: rtl/srt_pkg.sv
// Shared types and constants for the SRT divider quotient path.
package srt_pkg;

    localparam int DIGIT_W         = 3;
    localparam int NDIGITS_DEFAULT = 13;

    typedef logic signed [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WAIT_REM = 2'd2,
        DONE     = 2'd3
    } otf_state_t;

endpackage

// File: rtl/srt_otf_step.sv
// One on-the-fly conversion step: next Q / QM (QM = Q-1) for one signed
// radix-4 digit. Pure combinational; MSBs shifted out are dropped.
module srt_otf_step
    import srt_pkg::*;
#(
    parameter int QW = 26
) (
    input  logic [QW-1:0] q,
    input  logic [QW-1:0] qm,
    input  digit_t        d,
    output logic [QW-1:0] q_nxt,
    output logic [QW-1:0] qm_nxt
);

    // d-1 and d+3 in 3-bit two's complement; only the low 2 bits are appended.
    // (4+d) mod 4 equals d mod 4, so d[1:0] serves both Q branches.
    digit_t dm1;
    digit_t dp3;
    assign dm1 = d - 3'sd1;
    assign dp3 = d + 3'sd3;

    // Select the source register by digit sign and append the residue digit.
    always_comb begin
        q_nxt  = d[DIGIT_W-1] ? {qm[QW-3:0], d[1:0]} : {q[QW-3:0], d[1:0]};
        qm_nxt = (!d[DIGIT_W-1] && (d != 3'sd0)) ? {q[QW-3:0], dm1[1:0]}
                                                  : {qm[QW-3:0], dp3[1:0]};
    end

endmodule

// File: rtl/srt_otf_quotient_converter.sv
// On-the-fly quotient converter: accepts NDIGITS signed radix-4 digits,
// then picks Q or Q-1 by the final remainder sign and presents it.
// Optional macro SRT_OTF_DIGIT_CHECK_EN: treat digit -4 as 0 and flag
// err_illegal (sticky until rst or an accepted start).
module srt_otf_quotient_converter
    import srt_pkg::*;
#(
    parameter int NDIGITS = NDIGITS_DEFAULT,
    parameter int QW      = 2*NDIGITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               rem_valid,
    input  logic               rem_neg,
    output logic               q_valid,
    input  logic               q_ready,
    output logic [QW-1:0]      quotient,
    output logic               err_illegal
);

    localparam int CW = $clog2(NDIGITS+1);

    otf_state_t    state;
    logic [QW-1:0] q_r, qm_r, q_nxt, qm_nxt;
    logic [CW-1:0] cnt;
    logic [QW-1:0] quotient_r;
    digit_t        d_eff;
    logic          accept;
    logic          start_ok;

    assign busy        = (state != IDLE);
    assign digit_ready = (state == ACCUM);
    assign q_valid     = (state == DONE);
    assign quotient    = quotient_r;
    assign accept      = digit_ready & digit_valid;
    assign start_ok    = (state == IDLE) & start;

`ifdef SRT_OTF_DIGIT_CHECK_EN
    logic illegal;
    logic err_r;
    assign illegal     = (digit == 3'b100);
    assign d_eff       = illegal ? 3'sd0 : digit_t'(digit);
    assign err_illegal = err_r;

    // Sticky illegal-digit flag; a new conversion clears it.
    always_ff @(posedge clk) begin
        if (rst || start_ok) err_r <= 1'b0;
        else if (accept && illegal) err_r <= 1'b1;
    end
`else
    assign d_eff       = digit_t'(digit);
    assign err_illegal = 1'b0;
`endif

    srt_otf_step #(.QW(QW)) u_step (
        .q      (q_r),
        .qm     (qm_r),
        .d      (d_eff),
        .q_nxt  (q_nxt),
        .qm_nxt (qm_nxt)
    );

    // Control FSM plus Q/QM accumulation and final Q/QM selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            q_r        <= '0;
            qm_r       <= '1;
            cnt        <= '0;
            quotient_r <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= ACCUM;
                    q_r   <= '0;
                    qm_r  <= '1;
                    cnt   <= '0;
                end
                ACCUM: if (accept) begin
                    q_r  <= q_nxt;
                    qm_r <= qm_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(NDIGITS-1)) state <= WAIT_REM;
                end
                WAIT_REM: if (rem_valid) begin
                    quotient_r <= rem_neg ? qm_r : q_r;
                    state      <= DONE;
                end
                DONE: if (q_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/srt_otf_quotient_converter.md
Name: srt_otf_quotient_converter

Overview:
- Sequential consumer of the signed quotient digits produced by the SRT digit-selection stage. Digits lie in {-3..+3}, radix 4.
- Performs on-the-fly conversion: maintains registers Q and QM (QM = Q-1) and shifts in one digit per accepted handshake. No carry-propagate adder is used.
- After the last digit it takes the final-remainder sign, selects Q or QM, and presents the binary quotient on a valid/ready output.
- Sits between the divider iteration datapath and the result/normalisation stage.

Parameters:
- NDIGITS, 13, number of radix-4 quotient digits per division.
- QW, 2*NDIGITS, quotient width in bits (26 at default).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new conversion; honoured only in IDLE.
- busy  output  1  high in every state except IDLE.
- digit_valid  input  1  digit present.
- digit_ready  output  1  converter accepts a digit (high only in ACCUM).
- digit  input  3  signed two's-complement quotient digit, -3..+3.
- rem_valid  input  1  final remainder sign is available.
- rem_neg  input  1  final remainder is negative (sign bit of remainder).
- q_valid  output  1  quotient valid.
- q_ready  input  1  downstream accepts the quotient.
- quotient  output  QW  converted binary quotient, two's complement modulo 2^QW.
- err_illegal  output  1  illegal digit seen (only when the optional feature is compiled in).

Behaviour:
- Reset: state=IDLE; Q=0; QM=all ones; digit counter=0; quotient=0; q_valid=0; digit_ready=0; busy=0; err_illegal=0. A reset asserted in any state aborts the conversion with no output.
- IDLE:
  - start=1 -> next cycle ACCUM, with Q=0, QM=all ones (-1), count=0.
  - start=0 -> stay in IDLE.
- ACCUM:
  - digit_ready=1. A digit is accepted on a cycle with digit_valid & digit_ready.
  - Update with digit q, keeping the low QW bits (MSBs shifted out are discarded):
    - Q' = (q>=0) ? {Q,q[1:0]} : {QM,(4+q)[1:0]}
    - QM' = (q>0) ? {Q,(q-1)[1:0]} : {QM,(3+q)[1:0]}
  - count increments per accepted digit. The accept that makes count=NDIGITS moves to WAIT_REM on the next cycle.
  - No accept -> registers hold.
- WAIT_REM:
  - digit_ready=0. Waits for rem_valid.
  - If rem_valid is already high on the cycle of entry, it is honoured that cycle.
  - On rem_valid: quotient <= rem_neg ? QM : Q, q_valid <= 1 next cycle, state -> DONE.
- DONE:
  - q_valid=1 and quotient is stable until q_valid & q_ready.
  - On handshake -> IDLE next cycle, q_valid=0.
  - start is ignored until IDLE is reached, so there are no back-to-back starts inside DONE.
- Latency from last digit accept to q_valid is 2 cycles, provided rem_valid is high on WAIT_REM entry.
- start while busy is ignored. digit_valid outside ACCUM is ignored. rem_valid outside WAIT_REM is ignored.
- Wrap: a negative leading digit yields a two's-complement quotient modulo 2^QW. No overflow flag is produced.

Optional Feature:
- Macro SRT_OTF_DIGIT_CHECK_EN.
  - Defined: an accepted digit of 3'b100 (-4) is converted as 0, and err_illegal is set sticky. err_illegal clears on rst or an accepted start.
  - Undefined: err_illegal is tied 0 and -4 goes through the equations unmodified. The result is unspecified, and benches must not drive -4.

Decomposition:
- Shared package srt_pkg:
  - DIGIT_W=3
  - typedef logic signed [DIGIT_W-1:0] digit_t
  - NDIGITS_DEFAULT=13
  - enum otf_state_t {IDLE, ACCUM, WAIT_REM, DONE}
- One sub-module, srt_otf_step: combinational next-Q/QM computation from (Q, QM, digit). It is reusable by a future radix-2 variant.

Test Plan:
- Digits 12x0 then +1, rem_neg=0 -> quotient=26'h0000001. With rem_neg=1 -> 26'h0000000.
- Digits +1, -1, then 11x0, rem_neg=0 -> quotient=26'h0C00000. Same digits with rem_neg=1 -> 26'h0BFFFFF.
- Digits -1 then 12x0, rem_neg=0 -> quotient=26'h3000000 (wrap). All 13 digits +3 -> 26'h3FFFFFF.
- Backpressure checks:
  - digit_valid toggled 1/0 during accumulation.
  - rem_valid delayed 4 cycles.
  - q_ready held 0 for 5 cycles.
  - Required: quotient and q_valid stable throughout; exactly one handshake; then IDLE.
- rst pulsed after 5 digits -> next cycle busy=0, digit_ready=0, q_valid=0. A fresh start plus 13x0 with rem_neg=0 -> quotient=0.
- With SRT_OTF_DIGIT_CHECK_EN: digit -4 in position 3 -> err_illegal=1 and quotient equals the result with that digit as 0. err_illegal clears on the next start.
